seg_mux_ctrl: RTL

//  Time-multiplexing scheduler that shares one combinational hex-to-7-segment decoder between two digits.

---
 rtl/seg_mux_ctrl.sv | 86 ++++++++
 1 files changed

// File: rtl/seg_mux_ctrl.sv
// seg_mux_ctrl: two-digit time-multiplexing scheduler for a shared hex-to-7-segment decoder
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous active-high reset
//   s0, s1       digit pair offered for update
//   upd_valid    update request valid
//   upd_ready    shadow register free (handshake = upd_valid && upd_ready)
//   cur_s        value routed to the shared decoder
//   an           active-low anode enables, an[0]=digit 0, an[1]=digit 1
//   frame_start  one-cycle pulse on the first cycle of each SHOW0
module seg_mux_ctrl #(
    parameter int REFRESH_CNT = 24000,
    parameter int BLANK_CNT   = 240
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] s0,
    input  logic [3:0] s1,
    input  logic       upd_valid,
    output logic       upd_ready,
    output logic [3:0] cur_s,
    output logic [1:0] an,
    output logic       frame_start
);
    localparam int MAXC = (REFRESH_CNT > BLANK_CNT) ? REFRESH_CNT : BLANK_CNT;
    localparam int W = $clog2(MAXC + 1);
    localparam logic SKIP = (BLANK_CNT == 0);

    typedef enum logic [1:0] {SHOW0, BLANK0, SHOW1, BLANK1} state_t;

    state_t     state, nxt;
    logic [W-1:0] cnt;
    logic [3:0] act0, act1, sh0, sh1, cur_nxt;
    logic [1:0] an_nxt;
    logic       pending, show, adv, enter0, commit, accept;

    assign upd_ready = !pending;

    always_comb begin
        show    = (state == SHOW0) || (state == SHOW1);
        // with no blanking, a blank state (only reachable via reset) is left at once
        adv     = show ? (int'(cnt) == REFRESH_CNT - 1) : (SKIP || int'(cnt) == BLANK_CNT - 1);
        nxt     = !adv            ? state :
                  state == SHOW0  ? (SKIP ? SHOW1 : BLANK0) :
                  state == BLANK0 ? SHOW1 :
                  state == SHOW1  ? (SKIP ? SHOW0 : BLANK1) : SHOW0;
        enter0  = adv && (nxt == SHOW0);
        commit  = enter0 && pending;
        // accept and commit are exclusive: accept needs pending=0, commit needs pending=1
        accept  = upd_valid && !pending;
        an_nxt  = nxt == SHOW0 ? 2'b10 : nxt == SHOW1 ? 2'b01 : 2'b11;
        // the committed digit is shown in the very first SHOW0 cycle
        cur_nxt = nxt == SHOW0 ? (commit ? sh0 : act0) : nxt == SHOW1 ? act1 : cur_s;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= BLANK1;
            cnt         <= '0;
            act0        <= '0;
            act1        <= '0;
            sh0         <= '0;
            sh1         <= '0;
            pending     <= 1'b0;
            an          <= 2'b11;
            cur_s       <= 4'h0;
            frame_start <= 1'b0;
        end else begin
            state       <= nxt;
            cnt         <= adv ? '0 : cnt + W'(1);
            an          <= an_nxt;
            cur_s       <= cur_nxt;
            frame_start <= enter0;
            if (accept) begin
                sh0     <= s0;
                sh1     <= s1;
                pending <= 1'b1;
            end
            if (commit) begin
                act0    <= sh0;
                act1    <= sh1;
                pending <= 1'b0;
            end
        end
    end
endmodule
